// File: rtl/ar_burst_splitter.sv
// AXI read-address burst splitter.
// A long AR burst is cut into sub-bursts of at most 2**LOG_SUB_BEATS beats,
// issued back to back toward the prefetcher. A small tracker remembers
// {id, sub-burst count} per original burst so the returning R stream can be
// re-marked with a single last flag per original burst. R data never enters
// this block; only the R handshake, last and ID are observed here.
module ar_burst_splitter #(
  parameter int ADDR_BITS            = 64,
  parameter int BURST_LEN_WIDTH      = 8,
  parameter int TID_WIDTH            = 8,
  parameter int LOG_BLOCK_DATA_BYTES = 6,
  parameter int LOG_SUB_BEATS        = 2,
  parameter int LOG_TRACK_DEPTH      = 2
) (
  input  logic                       clk,
  input  logic                       resetN,
  input  logic                       s_ar_valid,
  output logic                       s_ar_ready,
  input  logic [0:BURST_LEN_WIDTH-1] s_ar_len,
  input  logic [0:ADDR_BITS-1]       s_ar_addr,
  input  logic [0:TID_WIDTH-1]       s_ar_id,
  output logic                       m_ar_valid,
  input  logic                       m_ar_ready,
  output logic [0:BURST_LEN_WIDTH-1] m_ar_len,
  output logic [0:ADDR_BITS-1]       m_ar_addr,
  output logic [0:TID_WIDTH-1]       m_ar_id,
  input  logic                       m_r_valid,
  output logic                       m_r_ready,
  input  logic                       m_r_last,
  input  logic [0:TID_WIDTH-1]       m_r_id,
  output logic                       s_r_valid,
  input  logic                       s_r_ready,
  output logic                       s_r_last,
  output logic [0:TID_WIDTH-1]       s_r_id,
  output logic [0:1]                 errorCode
);

  // remaining-sub-burst counter width and per-burst sub-burst count width
  localparam int REM_W = BURST_LEN_WIDTH - LOG_SUB_BEATS;
  localparam int CNT_W = REM_W + 1;
  localparam int DEPTH = 1 << LOG_TRACK_DEPTH;
  localparam int PTR_W = LOG_TRACK_DEPTH + 1;

  localparam logic [BURST_LEN_WIDTH-1:0] SUB_LEN_MAX =
    BURST_LEN_WIDTH'((1 << LOG_SUB_BEATS) - 1);
  localparam logic [ADDR_BITS-1:0] ADDR_STEP =
    ADDR_BITS'(1) << (LOG_SUB_BEATS + LOG_BLOCK_DATA_BYTES);

  typedef enum logic {
    ST_IDLE,
    ST_ISSUE
  } state_t;

  // Descending-range views of the port vectors (same bit weights)
  logic [BURST_LEN_WIDTH-1:0] ar_len;
  logic [ADDR_BITS-1:0]       ar_addr;
  logic [TID_WIDTH-1:0]       ar_id;
  logic [TID_WIDTH-1:0]       r_id;

  assign ar_len  = s_ar_len;
  assign ar_addr = s_ar_addr;
  assign ar_id   = s_ar_id;
  assign r_id    = m_r_id;

  // Splitter context
  state_t                     state_q, state_d;
  logic [ADDR_BITS-1:0]       addr_q, addr_d;
  logic [BURST_LEN_WIDTH-1:0] len_q, len_d;
  logic [TID_WIDTH-1:0]       id_q, id_d;
  logic [REM_W-1:0]           rem_q, rem_d;

  // Tracker FIFO and R-side bookkeeping
  logic [TID_WIDTH-1:0]       trk_id_q [DEPTH];
  logic [TID_WIDTH-1:0]       trk_id_d [DEPTH];
  logic [CNT_W-1:0]           trk_n_q  [DEPTH];
  logic [CNT_W-1:0]           trk_n_d  [DEPTH];
  logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]           sub_cnt_q, sub_cnt_d;
  // err bit 0: R beat with tracker empty; bit 1: R ID differs from head ID
  logic [1:0]                 err_q, err_d;

  logic [LOG_TRACK_DEPTH-1:0] wr_idx, rd_idx;
  logic                       trk_empty, trk_full;
  logic [TID_WIDTH-1:0]       head_id;
  logic [CNT_W-1:0]           head_n;
  logic                       head_last_sub;
  logic                       ar_ok;
  logic                       ar_hs, m_ar_hs, r_hs;
  logic                       push, pop;

  assign wr_idx    = wr_ptr_q[LOG_TRACK_DEPTH-1:0];
  assign rd_idx    = rd_ptr_q[LOG_TRACK_DEPTH-1:0];
  assign trk_empty = (wr_ptr_q == rd_ptr_q);
  // same slot index with opposite wrap bit means every entry is occupied
  assign trk_full  = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                     (wr_idx == rd_idx);
  assign head_id   = trk_id_q[rd_idx];
  assign head_n    = trk_n_q[rd_idx];
  assign head_last_sub = (sub_cnt_q == head_n - CNT_W'(1));

  // All tracked bursts share one ID, so comparing with the head suffices.
  assign ar_ok      = !trk_full && (trk_empty || (ar_id == head_id));
  // resetN gating keeps ready low while reset is held, not just after it
  assign s_ar_ready = resetN && (state_q == ST_IDLE) && ar_ok;
  assign m_ar_valid = (state_q == ST_ISSUE);
  assign m_ar_addr  = addr_q;
  assign m_ar_id    = id_q;
  assign m_ar_len   = (rem_q != '0) ? SUB_LEN_MAX
                                    : BURST_LEN_WIDTH'(len_q[LOG_SUB_BEATS-1:0]);

  assign ar_hs   = s_ar_valid && s_ar_ready;
  assign m_ar_hs = m_ar_valid && m_ar_ready;

  // R path is a straight wire apart from the re-derived last flag.
  assign s_r_valid = m_r_valid;
  assign m_r_ready = s_r_ready;
  assign s_r_id    = m_r_id;
  assign r_hs      = m_r_valid && s_r_ready;
  // With nothing tracked the beat is passed on with its own last flag.
  assign s_r_last  = m_r_last && (trk_empty || head_last_sub);

  assign push = ar_hs;
  assign pop  = r_hs && m_r_last && !trk_empty && head_last_sub;

  // Numeric weight is preserved: errorCode value 2'b10 means ID mismatch.
  assign errorCode = err_q;

  // Splitter FSM: latch the burst in IDLE, walk the sub-bursts in ISSUE
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    id_d    = id_q;
    rem_d   = rem_q;
    unique case (state_q)
      ST_IDLE: begin
        if (ar_hs) begin
          addr_d  = ar_addr;
          len_d   = ar_len;
          id_d    = ar_id;
          rem_d   = ar_len[BURST_LEN_WIDTH-1:LOG_SUB_BEATS];
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (m_ar_hs) begin
          if (rem_q != '0) begin
            // wraps silently at the top of the address space
            addr_d = addr_q + ADDR_STEP;
            rem_d  = rem_q - REM_W'(1);
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Tracker push/pop, sub-burst counting on R and sticky error capture
  always_comb begin
    trk_id_d  = trk_id_q;
    trk_n_d   = trk_n_q;
    wr_ptr_d  = wr_ptr_q + PTR_W'(push);
    rd_ptr_d  = rd_ptr_q + PTR_W'(pop);
    sub_cnt_d = sub_cnt_q;
    err_d     = err_q;
    if (push) begin
      trk_id_d[wr_idx] = ar_id;
      trk_n_d[wr_idx]  = CNT_W'(ar_len[BURST_LEN_WIDTH-1:LOG_SUB_BEATS]) + CNT_W'(1);
    end
    if (r_hs && m_r_last && !trk_empty) begin
      sub_cnt_d = head_last_sub ? '0 : sub_cnt_q + CNT_W'(1);
    end
    if (r_hs && trk_empty) begin
      err_d[0] = 1'b1;
    end
    if (r_hs && !trk_empty && (r_id != head_id)) begin
      err_d[1] = 1'b1;
    end
  end

  // Control state: asynchronously cleared, discarding any in-flight burst
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q   <= ST_IDLE;
      rem_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      sub_cnt_q <= '0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      sub_cnt_q <= sub_cnt_d;
      err_q     <= err_d;
    end
  end

  // Payload registers: only meaningful while qualified by control state
  always_ff @(posedge clk) begin
    addr_q   <= addr_d;
    len_q    <= len_d;
    id_q     <= id_d;
    trk_id_q <= trk_id_d;
    trk_n_q  <= trk_n_d;
  end

endmodule

// File: tb/tb_ar_burst_splitter.sv
// Bench for ar_burst_splitter: directed bursts with a queue-based model of
// the expected sub-burst sequence, tracker occupancy and error flags.
module tb_ar_burst_splitter;

  logic        clk = 1'b0;
  logic        resetN;
  logic        s_ar_valid, s_ar_ready;
  logic [7:0]  s_ar_len;
  logic [63:0] s_ar_addr;
  logic [7:0]  s_ar_id;
  logic        m_ar_valid, m_ar_ready;
  logic [7:0]  m_ar_len;
  logic [63:0] m_ar_addr;
  logic [7:0]  m_ar_id;
  logic        m_r_valid, m_r_ready, m_r_last;
  logic [7:0]  m_r_id;
  logic        s_r_valid, s_r_ready, s_r_last;
  logic [7:0]  s_r_id;
  logic [1:0]  error_code;

  always #5 clk = ~clk;

  ar_burst_splitter dut (
    .clk(clk), .resetN(resetN),
    .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready), .s_ar_len(s_ar_len),
    .s_ar_addr(s_ar_addr), .s_ar_id(s_ar_id),
    .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready), .m_ar_len(m_ar_len),
    .m_ar_addr(m_ar_addr), .m_ar_id(m_ar_id),
    .m_r_valid(m_r_valid), .m_r_ready(m_r_ready), .m_r_last(m_r_last), .m_r_id(m_r_id),
    .s_r_valid(s_r_valid), .s_r_ready(s_r_ready), .s_r_last(s_r_last), .s_r_id(s_r_id),
    .errorCode(error_code)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // ---------------- model ----------------
  typedef struct {
    logic [63:0] addr;
    logic [7:0]  len;
    logic [7:0]  id;
  } sub_t;
  typedef struct {
    logic [7:0] id;
    int         n;
  } trk_t;

  sub_t pend[$];     // sub-bursts still owed on m_ar, in order
  trk_t trk[$];      // original bursts awaiting their final R beat
  int   cnt = 0;     // sub-burst lasts seen for the head burst
  logic [1:0] err = 2'b00;
  sub_t mlog[$];     // observed m_ar handshakes
  bit   rlog[$];     // observed s_r_last per R handshake

  bit exp_mv, exp_sar, exp_last;

  task automatic model_accept(input logic [7:0] id, input logic [7:0] len,
                              input logic [63:0] addr);
    int   nsub;
    sub_t s;
    trk_t t;
    nsub = int'(len) / 4 + 1;
    for (int k = 0; k < nsub; k++) begin
      s.addr = addr + 64'(k) * 64'h100;
      s.len  = (k < nsub - 1) ? 8'd3 : (len % 8'd4);
      s.id   = id;
      pend.push_back(s);
    end
    t.id = id;
    t.n  = nsub;
    trk.push_back(t);
  endtask

  // Compare every cycle on the falling edge, then advance the model with
  // the handshakes that the coming rising edge will complete.
  always @(negedge clk) begin
    if (!resetN) begin
      pend.delete();
      trk.delete();
      cnt = 0;
      err = 2'b00;
      chk("rst_m_ar_valid", 64'(m_ar_valid), 64'd0);
      chk("rst_s_ar_ready", 64'(s_ar_ready), 64'd0);
      chk("rst_error_code", 64'(error_code), 64'd0);
    end else begin
      exp_mv = (pend.size() > 0);
      chk("m_ar_valid", 64'(m_ar_valid), 64'(exp_mv));
      if (exp_mv) begin
        chk("m_ar_addr", m_ar_addr, pend[0].addr);
        chk("m_ar_len", 64'(m_ar_len), 64'(pend[0].len));
        chk("m_ar_id", 64'(m_ar_id), 64'(pend[0].id));
      end
      exp_sar = !exp_mv && (trk.size() < 4) &&
                (trk.size() == 0 || s_ar_id == trk[0].id);
      chk("s_ar_ready", 64'(s_ar_ready), 64'(exp_sar));
      chk("s_r_valid", 64'(s_r_valid), 64'(m_r_valid));
      chk("m_r_ready", 64'(m_r_ready), 64'(s_r_ready));
      chk("s_r_id", 64'(s_r_id), 64'(m_r_id));
      exp_last = m_r_last && (trk.size() == 0 || cnt == trk[0].n - 1);
      chk("s_r_last", 64'(s_r_last), 64'(exp_last));
      chk("error_code", 64'(error_code), 64'(err));

      if (m_r_valid && s_r_ready) begin
        rlog.push_back(s_r_last);
        if (trk.size() == 0) begin
          err[0] = 1'b1;
        end else begin
          if (m_r_id != trk[0].id) err[1] = 1'b1;
          if (m_r_last) begin
            if (cnt == trk[0].n - 1) begin
              void'(trk.pop_front());
              cnt = 0;
            end else begin
              cnt++;
            end
          end
        end
      end
      if (s_ar_valid && exp_sar) model_accept(s_ar_id, s_ar_len, s_ar_addr);
      if (m_ar_valid && m_ar_ready) begin
        sub_t s;
        s.addr = m_ar_addr;
        s.len  = m_ar_len;
        s.id   = m_ar_id;
        mlog.push_back(s);
        if (exp_mv) void'(pend.pop_front());
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_ar(input logic [7:0] id, input logic [7:0] len,
                         input logic [63:0] addr);
    int n;
    n = 0;
    s_ar_valid = 1'b1;
    s_ar_id    = id;
    s_ar_len   = len;
    s_ar_addr  = addr;
    while (1) begin
      @(negedge clk);
      if (s_ar_ready) break;
      n++;
      if (n > 200) begin
        chk("ar_accept_timeout", 64'(s_ar_ready), 64'd1);
        break;
      end
    end
    tick();
    s_ar_valid = 1'b0;
  endtask

  task automatic wait_ar_idle();
    int n;
    n = 0;
    while (m_ar_valid === 1'b1 && n < 300) begin
      tick();
      n++;
    end
    chk("ar_drain", 64'(m_ar_valid), 64'd0);
  endtask

  task automatic r_beat(input logic [7:0] id, input logic last);
    m_r_valid = 1'b1;
    m_r_id    = id;
    m_r_last  = last;
    tick();
    m_r_valid = 1'b0;
    m_r_last  = 1'b0;
  endtask

  // R beats for one original burst: sub-burst last every 4th beat and at the end
  task automatic send_burst_r(input logic [7:0] id, input int len);
    for (int i = 0; i <= len; i++) r_beat(id, ((i % 4) == 3) || (i == len));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time_limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int ones;
    resetN = 1'b0;
    s_ar_valid = 1'b0; s_ar_len = '0; s_ar_addr = '0; s_ar_id = '0;
    m_ar_ready = 1'b1;
    m_r_valid = 1'b0; m_r_last = 1'b0; m_r_id = '0;
    s_r_ready = 1'b1;
    #2;
    chk("reset_m_ar_valid", 64'(m_ar_valid), 64'd0);
    chk("reset_s_ar_ready", 64'(s_ar_ready), 64'd0);
    chk("reset_error_code", 64'(error_code), 64'd0);
    repeat (3) @(posedge clk);
    #1 resetN = 1'b1;
    tick();

    // len=9 at 0x1000: three sub-bursts, one final last after 10 beats
    mlog.delete();
    send_ar(8'd1, 8'd9, 64'h1000);
    wait_ar_idle();
    chk("t1_nsub", 64'(mlog.size()), 64'd3);
    if (mlog.size() == 3) begin
      chk("t1_addr0", mlog[0].addr, 64'h1000);
      chk("t1_len0", 64'(mlog[0].len), 64'd3);
      chk("t1_addr1", mlog[1].addr, 64'h1100);
      chk("t1_len1", 64'(mlog[1].len), 64'd3);
      chk("t1_addr2", mlog[2].addr, 64'h1200);
      chk("t1_len2", 64'(mlog[2].len), 64'd1);
    end
    rlog.delete();
    send_burst_r(8'd1, 9);
    chk("t1_nbeats", 64'(rlog.size()), 64'd10);
    ones = 0;
    foreach (rlog[i]) if (i < 9 && rlog[i]) ones++;
    chk("t1_early_last", 64'(ones), 64'd0);
    if (rlog.size() == 10) chk("t1_last_beat10", 64'(rlog[9]), 64'd1);

    // len=2: single sub-burst at the original address
    mlog.delete();
    send_ar(8'd2, 8'd2, 64'h2000);
    wait_ar_idle();
    chk("t2_nsub", 64'(mlog.size()), 64'd1);
    if (mlog.size() == 1) begin
      chk("t2_addr", mlog[0].addr, 64'h2000);
      chk("t2_len", 64'(mlog[0].len), 64'd2);
    end
    rlog.delete();
    send_burst_r(8'd2, 2);
    if (rlog.size() == 3) chk("t2_last_beat3", 64'(rlog[2]), 64'd1);
    s_ar_id = 8'h09;
    #1 chk("t2_tracker_empty", 64'(s_ar_ready), 64'd1);

    // back-pressure mid-split: request must hold, nothing skipped or repeated
    m_ar_ready = 1'b0;
    mlog.delete();
    send_ar(8'd3, 8'd11, 64'h3000);
    repeat (2) tick();
    m_ar_ready = 1'b1;
    tick();
    m_ar_ready = 1'b0;
    repeat (5) begin
      tick();
      chk("t3_hold_addr", m_ar_addr, 64'h3100);
      chk("t3_hold_len", 64'(m_ar_len), 64'd3);
    end
    m_ar_ready = 1'b1;
    wait_ar_idle();
    chk("t3_nsub", 64'(mlog.size()), 64'd3);
    if (mlog.size() == 3) begin
      chk("t3_addr1", mlog[1].addr, 64'h3100);
      chk("t3_addr2", mlog[2].addr, 64'h3200);
      chk("t3_len2", 64'(mlog[2].len), 64'd3);
    end
    send_burst_r(8'd3, 11);

    // tracker full: fifth same-ID burst stalls until one burst completes
    for (int k = 0; k < 4; k++) begin
      send_ar(8'd4, 8'd3, 64'h4000 + 64'(k) * 64'h100);
      wait_ar_idle();
    end
    s_ar_valid = 1'b1; s_ar_id = 8'd4; s_ar_len = 8'd3; s_ar_addr = 64'h4400;
    repeat (3) begin
      @(negedge clk);
      chk("t4_stall_full", 64'(s_ar_ready), 64'd0);
    end
    tick();
    send_burst_r(8'd4, 3);
    @(negedge clk);
    chk("t4_accept_after_pop", 64'(s_ar_ready), 64'd1);
    tick();
    s_ar_valid = 1'b0;
    wait_ar_idle();
    repeat (4) send_burst_r(8'd4, 3);

    // different ID stalls; mismatching R ID sets the sticky bit 1
    send_ar(8'd5, 8'd0, 64'h7000);
    wait_ar_idle();
    s_ar_valid = 1'b1; s_ar_id = 8'd7; s_ar_len = 8'd0; s_ar_addr = 64'h8000;
    repeat (3) begin
      @(negedge clk);
      chk("t5_stall_id", 64'(s_ar_ready), 64'd0);
    end
    tick();
    r_beat(8'd3, 1'b1);
    chk("t5_err_mismatch", 64'(error_code), 64'h2);
    @(negedge clk);
    chk("t5_accept_after_drain", 64'(s_ar_ready), 64'd1);
    tick();
    s_ar_valid = 1'b0;
    wait_ar_idle();
    r_beat(8'd7, 1'b1);
    chk("t5_err_sticky", 64'(error_code), 64'h2);

    // R beat with nothing tracked
    r_beat(8'd9, 1'b1);
    chk("t6_err_empty", 64'(error_code), 64'h3);

    // reset after the first sub-burst of a split
    m_ar_ready = 1'b0;
    send_ar(8'd8, 8'd9, 64'h5000);
    m_ar_ready = 1'b1;
    tick();
    m_ar_ready = 1'b0;
    #3 resetN = 1'b0;
    #1;
    chk("t7_rst_m_ar_valid", 64'(m_ar_valid), 64'd0);
    chk("t7_rst_s_ar_ready", 64'(s_ar_ready), 64'd0);
    chk("t7_rst_error_code", 64'(error_code), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1 resetN = 1'b1;
    m_ar_ready = 1'b1;
    mlog.delete();
    tick();
    chk("t7_no_resume", 64'(m_ar_valid), 64'd0);
    send_ar(8'd8, 8'd5, 64'h6000);
    wait_ar_idle();
    chk("t7_nsub", 64'(mlog.size()), 64'd2);
    if (mlog.size() == 2) begin
      chk("t7_addr0", mlog[0].addr, 64'h6000);
      chk("t7_len0", 64'(mlog[0].len), 64'd3);
      chk("t7_addr1", mlog[1].addr, 64'h6100);
      chk("t7_len1", 64'(mlog[1].len), 64'd1);
    end
    rlog.delete();
    send_burst_r(8'd8, 5);
    if (rlog.size() == 6) begin
      chk("t7_no_last_beat4", 64'(rlog[3]), 64'd0);
      chk("t7_last_beat6", 64'(rlog[5]), 64'd1);
    end
    repeat (2) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
